// File: rtl/serial_frame_rcv.sv
// Receive side of the serial link: synchronizes the idle-high line, times each
// start/data/stop bit from the start edge and hands complete words to the consumer.
module serial_frame_rcv #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int SHIFT_MSB    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 rcving
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, next_state;

  logic                 sync_1;
  logic                 line;
  logic                 line_prev;
  logic                 start_edge;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 sample_start;
  logic                 sample_bit;
  logic                 sample_stop;

  // Synchronizer and edge flops come out of reset high so an idle line never looks like a start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_1    <= 1'b1;
      line      <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_1    <= serial_in;
      line      <= sync_1;
      line_prev <= line;
    end
  end

  assign start_edge = !line && line_prev;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    sample_start = 1'b0;
    sample_bit   = 1'b0;
    sample_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          next_state = START;
        end
      end
      START: begin
        if (tick_cnt == HALF_TICK) begin
          sample_start = 1'b1;
          next_state   = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_cnt == LAST_TICK) begin
          sample_bit = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            next_state = STOP;
          end
        end
      end
      STOP: begin
        if (tick_cnt == LAST_TICK) begin
          sample_stop = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The half-bit START phase restarts the counter so every later sample lands mid-bit.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tick_cnt <= '0;
    end else if (state == IDLE || sample_start || tick_cnt == LAST_TICK) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bit_cnt <= '0;
    end else if (sample_start) begin
      bit_cnt <= '0;
    end else if (sample_bit) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shift_reg <= '0;
    end else if (sample_bit) begin
      if (SHIFT_MSB != 0) begin
        shift_reg <= {shift_reg[DATA_BITS-2:0], line};
      end else begin
        shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      framing_error <= 1'b0;
    end else if (sample_start && !line) begin
      framing_error <= 1'b0;
    end else if (sample_stop && !line) begin
      framing_error <= 1'b1;
    end
  end

  // A good-stop load beats a coincident read; the read still counts against overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end else if (sample_stop && line) begin
      rx_data       <= shift_reg;
      data_ready    <= 1'b1;
      overrun_error <= data_ready && !data_read;
    end else if (data_read && data_ready) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

  assign rcving = (state != IDLE);

endmodule

// File: doc/serial_frame_rcv.md
Name: serial_frame_rcv

Overview:
Receive side of the team's serial link. It accepts the idle-high, start/stop-framed bit stream produced by the parallel-to-serial transmit path and reassembles each word into a parallel register. The block contains a synchronizer, a start-edge detector, a per-bit timing counter, a frame FSM, an internal serial-to-parallel shift register, and a ready/read handshake with error flags toward the consuming logic.

Parameters:
DATA_BITS, 8, payload bits per frame; must be >= 2.
CLKS_PER_BIT, 10, clk cycles per serial bit; must be >= 4.
SHIFT_MSB, 0, bit order. 1 = the transmitter sends MSB first. 0 = the transmitter sends LSB first.

Ports:
clk  input  1  system clock, rising-edge.
n_rst  input  1  reset, asynchronous, active-low.
serial_in  input  1  asynchronous serial line; idles high.
data_read  input  1  single-cycle pulse; the consumer has taken rx_data.
rx_data  output  DATA_BITS  last good received word.
data_ready  output  1  rx_data holds an unread word.
overrun_error  output  1  a word was overwritten before it was read.
framing_error  output  1  the last frame had a bad stop bit.
rcving  output  1  a frame is in progress.

Behaviour:
- Reset (async): rx_data=0, data_ready=0, overrun_error=0, framing_error=0, rcving=0, FSM=IDLE, counters=0. Synchronizer and edge flops reset to 1 so an idle line gives no edge.
- Synchronizer: 2 flops; "line" means the synchronized value. Edge register holds the previous line value.
- Start edge: line=0 and previous=1. Detected in any state, but it only acts in IDLE. Call the detect cycle D.
- FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a start edge. rcving=1 from cycle D+1.
- START: sample line at D+H, where H=floor(CLKS_PER_BIT/2).
  - line=0: go to DATA, clear the bit counter, clear framing_error.
  - line=1: false start; go to IDLE, rcving=0, no other output changes.
- DATA: data bit i (i=0..DATA_BITS-1) is sampled at D+H+(i+1)*CLKS_PER_BIT. The timing counter wraps at CLKS_PER_BIT-1.
  - SHIFT_MSB=1: the shift register shifts left and the sample enters bit 0.
  - SHIFT_MSB=0: the shift register shifts right and the sample enters bit DATA_BITS-1.
  - After bit DATA_BITS-1, go to STOP.
- STOP: sample at D+H+(DATA_BITS+1)*CLKS_PER_BIT, then go to IDLE. rcving=0 from the next cycle.
  - stop=1: rx_data <= shift register and data_ready <= 1, effective the next cycle. If data_ready was already 1 and data_read is not asserted in the stop cycle, overrun_error <= 1.
  - stop=0: framing_error <= 1. rx_data, data_ready and overrun_error are unchanged.
- Back-to-back frames: a start edge in the cycle after the stop sample, or later, starts a new frame with no dead time required.
- data_read: clears data_ready and overrun_error on the next edge.
  - If data_read coincides with a good-stop load, the load wins: data_ready=1 and overrun_error is cleared.
  - data_read while data_ready=0 has no effect.
- framing_error is sticky until the next valid start bit (START sample=0) or reset.
- Reset mid-frame: everything returns to reset values immediately and the partial word is discarded.
- The shift register holds its value outside DATA.

Test Plan:
1. LSB-first (SHIFT_MSB=0), frame 0xA5 with stop=1, idle before and after -> rx_data=0xA5, data_ready=1 at stop sample+1, framing_error=0. rcving is high D+1 through the stop sample.
2. Line low for 3 cycles, then high (glitch) -> start sample sees 1, FSM returns to IDLE, rcving drops, data_ready/rx_data unchanged.
3. After test 1 (unread), frame 0x3C with stop=0 -> framing_error=1, rx_data stays 0xA5, data_ready stays 1, overrun_error=0. A following good frame 0x0F clears framing_error at its start sample.
4. Back-to-back frames 0x11 then 0x22, no data_read -> rx_data=0x22, data_ready=1, overrun_error=1. A data_read pulse clears data_ready and overrun_error on the next cycle.
5. data_ready=1, and data_read is pulsed exactly in the stop-sample cycle of frame 0x55 -> next cycle rx_data=0x55, data_ready=1, overrun_error=0.
6. SHIFT_MSB=1, frame 0xA5 sent MSB first -> rx_data=0xA5. Then assert n_rst during data bit 3 and release with the line high -> all outputs 0, no spurious start. The next frame 0x0F is received correctly.
